// File: rtl/register_4bit.sv
// -----------------------------------------------------------------------------
// register_4bit
//
// Parallel-load storage register. q captures d on a rising clk edge when load
// is high and holds its value otherwise. An asynchronous active-low reset
// forces q to RESET_VALUE immediately, with no clock required.
//
// Parameters:
//   WIDTH        data width in bits (1 and up), default 4
//   RESET_VALUE  value placed on q while rst_n is low, default 0
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   load   in   1      load enable, sampled on the rising edge of clk
//   d      in   WIDTH  parallel data in
//   q      out  WIDTH  registered data out, driven directly from flops
//
// Interface semantics: load is a plain enable strobe with no handshake and
// no back-pressure; every rising edge with load = 1 overwrites the stored
// value, and every edge with load = 0 leaves it untouched.
// -----------------------------------------------------------------------------
module register_4bit #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state: take d when enabled, otherwise recirculate the stored value.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  // Reset is in the sensitivity list so assertion acts without a clock and
  // wins over any load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // No logic between the flops and the output.
  assign q = q_q;

endmodule

// File: tb/tb_register_4bit.sv
module tb_register_4bit;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;

  // Second instance exercising non-default parameters.
  logic       rst_n8;
  logic       load8;
  logic [7:0] d8;
  logic [7:0] q8;

  int vec_cnt;
  int err_cnt;

  register_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d),
    .q     (q)
  );

  register_4bit #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .load  (load8),
    .d     (d8),
    .q     (q8)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge.
  task automatic drive(input logic ld, input logic [3:0] dv);
    @(negedge clk);
    load = ld;
    d    = dv;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Hold reset with an active load of all ones while the clock runs.
    rst_n = 1'b0;
    load  = 1'b1;
    d     = 4'hF;
    #1;
    vec_cnt++;
    if (q !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_initial: q=%h expected=%h", q, 4'h0);
    end
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      vec_cnt++;
      if (q !== 4'h0) begin
        err_cnt++;
        $display("FAIL reset_held edge %0d: q=%h expected=%h", i, q, 4'h0);
      end
    end
    // Release with load low; q must stay at the reset value.
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    edge_sample();
    vec_cnt++;
    if (q !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_release: q=%h expected=%h", q, 4'h0);
    end
  endtask

  task automatic test_load_hold();
    logic       ld_t [3];
    logic [3:0] d_t  [3];
    logic [3:0] exp_t[3];
    ld_t = '{1'b1, 1'b0, 1'b1};
    d_t  = '{4'h5, 4'h9, 4'hC};
    exp_t = '{4'h5, 4'h5, 4'hC};
    for (int i = 0; i < 3; i++) begin
      drive(ld_t[i], d_t[i]);
      edge_sample();
      vec_cnt++;
      if (q !== exp_t[i]) begin
        err_cnt++;
        $display("FAIL load_hold step %0d: q=%h expected=%h", i, q, exp_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d_t[4];
    d_t = '{4'h0, 4'hF, 4'hA, 4'h5};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d_t[i]);
      edge_sample();
      vec_cnt++;
      if (q !== d_t[i]) begin
        err_cnt++;
        $display("FAIL back_to_back step %0d: q=%h expected=%h", i, q, d_t[i]);
      end
    end
  endtask

  task automatic test_hold_stability();
    drive(1'b1, 4'h7);
    edge_sample();
    vec_cnt++;
    if (q !== 4'h7) begin
      err_cnt++;
      $display("FAIL hold_preload: q=%h expected=%h", q, 4'h7);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'(i));
      edge_sample();
      vec_cnt++;
      if (q !== 4'h7) begin
        err_cnt++;
        $display("FAIL hold_stability edge %0d: q=%h expected=%h", i, q, 4'h7);
      end
    end
  endtask

  task automatic test_load_glitch();
    // load pulses between edges but is low at the edge: no capture.
    @(negedge clk);
    load = 1'b1;
    d    = 4'h2;
    #2;
    load = 1'b0;
    edge_sample();
    vec_cnt++;
    if (q !== 4'h7) begin
      err_cnt++;
      $display("FAIL load_glitch: q=%h expected=%h", q, 4'h7);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'hC);
    edge_sample();
    vec_cnt++;
    if (q !== 4'hC) begin
      err_cnt++;
      $display("FAIL async_preload: q=%h expected=%h", q, 4'hC);
    end
    // Assert reset mid-cycle, well before the next rising edge.
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (q !== 4'h0) begin
      err_cnt++;
      $display("FAIL async_assert: q=%h expected=%h", q, 4'h0);
    end
    #2;
    rst_n = 1'b1;
    drive(1'b1, 4'h3);
    edge_sample();
    vec_cnt++;
    if (q !== 4'h3) begin
      err_cnt++;
      $display("FAIL async_reload: q=%h expected=%h", q, 4'h3);
    end
  endtask

  task automatic test_param();
    @(negedge clk);
    rst_n8 = 1'b0;
    load8  = 1'b1;
    d8     = 8'hFF;
    #1;
    vec_cnt++;
    if (q8 !== 8'hA5) begin
      err_cnt++;
      $display("FAIL param_reset: q=%h expected=%h", q8, 8'hA5);
    end
    edge_sample();
    vec_cnt++;
    if (q8 !== 8'hA5) begin
      err_cnt++;
      $display("FAIL param_reset_edge: q=%h expected=%h", q8, 8'hA5);
    end
    @(negedge clk);
    load8  = 1'b0;
    rst_n8 = 1'b1;
    @(negedge clk);
    load8 = 1'b1;
    d8    = 8'h3C;
    edge_sample();
    vec_cnt++;
    if (q8 !== 8'h3C) begin
      err_cnt++;
      $display("FAIL param_load: q=%h expected=%h", q8, 8'h3C);
    end
    @(negedge clk);
    load8 = 1'b0;
    d8    = 8'hC3;
    edge_sample();
    vec_cnt++;
    if (q8 !== 8'h3C) begin
      err_cnt++;
      $display("FAIL param_hold: q=%h expected=%h", q8, 8'h3C);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n8  = 1'b0;
    load8   = 1'b0;
    d8      = 8'h00;

    test_reset();
    test_load_hold();
    test_back_to_back();
    test_hold_stability();
    test_load_glitch();
    test_async_reset();
    test_param();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
